// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, WIDTH+1 cycles per add.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output Ovf.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ADD    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    // Holds the first WIDTH-1 result bits; the last bit goes straight into Sum.
    logic [WIDTH-2:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] shifted;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign shifted   = {bit_s, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nxt;
                res_d   = shifted[WIDTH-1:1];
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    sum_d   = shifted;
                    cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final slice.
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    assign Busy = (state_q == ADD);
    assign Done = (state_q == FINISH);
    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Define SERIAL_ADDER_OVF_EN to also check the Ovf output.
module tb_serial_adder;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       Ovf;
`endif

    int checks;
    int failures;
    int dones;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(
        .WIDTH(8)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Busy   (Busy),
        .Done   (Done),
        .Sum    (Sum),
        .Cout   (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf    (Ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec);
        A = a;
        B = b;
        Cin = cin;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        A = ~a;
        B = ~b;
        Cin = ~cin;
        for (int i = 0; i < 8; i++) begin
            check_eq("busy_in_add", 32'(Busy), 32'd1);
            check_eq("no_early_done", 32'(Done), 32'd0);
            check_eq("sum_held", 32'(Sum), 32'(last_sum));
            check_eq("cout_held", 32'(Cout), 32'(last_cout));
            tick();
        end
        check_eq("done_pulse", 32'(Done), 32'd1);
        check_eq("busy_low_finish", 32'(Busy), 32'd0);
        check_eq("sum", 32'(Sum), 32'(es));
        check_eq("cout", 32'(Cout), 32'(ec));
        last_sum = es;
        last_cout = ec;
        tick();
        check_eq("done_one_cycle", 32'(Done), 32'd0);
        check_eq("idle_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_sum = 8'h00;
        last_cout = 1'b0;
        Start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        Cin = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_sum", 32'(Sum), 32'd0);
        check_eq("rst_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("rst_ovf", 32'(Ovf), 32'd0);
`endif
        Reset_n = 1'b1;
        tick();
        check_eq("idle_no_start", 32'(Busy), 32'd0);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Back-to-back: Start held high, second operands offered in the FINISH cycle.
        A = 8'h01;
        B = 8'h02;
        Cin = 1'b0;
        Start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b_busy1", 32'(Busy), 32'd1);
            check_eq("b2b_hold1", 32'(Sum), 32'h0FF);
            tick();
        end
        check_eq("b2b_done1", 32'(Done), 32'd1);
        check_eq("b2b_sum1", 32'(Sum), 32'h03);
        check_eq("b2b_cout1", 32'(Cout), 32'd0);
        A = 8'h10;
        B = 8'h20;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b_busy2", 32'(Busy), 32'd1);
            check_eq("b2b_nodone2", 32'(Done), 32'd0);
            check_eq("b2b_hold2", 32'(Sum), 32'h03);
            tick();
        end
        check_eq("b2b_done2", 32'(Done), 32'd1);
        check_eq("b2b_sum2", 32'(Sum), 32'h30);
        Start = 1'b0;
        tick();
        check_eq("b2b_idle", 32'({Busy, Done}), 32'd0);
        last_sum = 8'h30;
        last_cout = 1'b0;

        // Start re-pulsed in cycle 3 of ADD must be ignored.
        A = 8'h12;
        B = 8'h34;
        Cin = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        A = 8'hAA;
        B = 8'h55;
        Cin = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        check_eq("ign_done", 32'(Done), 32'd1);
        check_eq("ign_sum", 32'(Sum), 32'h46);
        check_eq("ign_cout", 32'(Cout), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done || Busy) dones++;
        end
        check_eq("ign_single_done", 32'(dones), 32'd0);
        last_sum = 8'h46;
        last_cout = 1'b0;

        // Reset in cycle 4 of ADD aborts immediately.
        A = 8'h0F;
        B = 8'h0F;
        Start = 1'b1;
        Cin = 1'b0;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        check_eq("abort_pre_busy", 32'(Busy), 32'd1);
        Reset_n = 1'b0;
        #2;
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_done", 32'(Done), 32'd0);
        check_eq("abort_sum", 32'(Sum), 32'd0);
        check_eq("abort_cout", 32'(Cout), 32'd0);
        tick();
        Reset_n = 1'b1;
        last_sum = 8'h00;
        last_cout = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done || Busy) dones++;
        end
        check_eq("abort_no_done", 32'(dones), 32'd0);

        run_op(8'h0F, 8'h0F, 1'b0, 8'h1E, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf_set", 32'(Ovf), 32'd1);
`endif
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf_clear", 32'(Ovf), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
